// File: rtl/control_sequencer.sv
// control_sequencer: timing and decode front end of the basic-computer control
// path. Holds the run flag S, the 3-bit sequence counter SC, the instruction
// register IR and the indirect flip-flop I. It produces the one-hot timing bus
// T0..T7, the opcode decode bus D0..D7 and the r/p strobes for the per-register
// control units.
module control_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] mem_data,
    output logic [7:0]  dec_out1,
    output logic [7:0]  dec_out2,
    output logic        iff_data,
    output logic        r,
    output logic        p,
    output logic [11:0] ir_data,
    output logic        ir_load,
    output logic        sc_clr,
    output logic        running
);

    // Run flag S expressed as a two-state machine.
    typedef enum logic {
        HALTED  = 1'b0,
        RUNNING = 1'b1
    } runState_t;

    runState_t   runState_q, runState_d;
    logic [2:0]  seqCount_q, seqCount_d;
    logic [15:0] instr_q,    instr_d;
    logic        indirect_q, indirect_d;

    logic [7:0]  timingBus;
    logic [7:0]  opDecode;
    logic        isRunning;
    logic        regRef;
    logic        ioRef;
    logic        endOfInstr;
    logic        haltNow;

    // Timing bus, opcode decode and end-of-instruction logic, all derived
    // purely from registered state so that start and mem_data never reach
    // an output combinationally.
    always_comb begin
        isRunning  = (runState_q == RUNNING);
        timingBus  = isRunning ? (8'h01 << seqCount_q) : 8'h00;
        opDecode   = 8'h01 << instr_q[14:12];
        regRef     = opDecode[7] & ~indirect_q & timingBus[3];
        ioRef      = opDecode[7] &  indirect_q & timingBus[3];
        endOfInstr = isRunning &
                     (regRef | ioRef |
                      ((opDecode[0] | opDecode[1] | opDecode[2] | opDecode[5]) & timingBus[5]) |
                      ((opDecode[3] | opDecode[4]) & timingBus[4]) |
                      (opDecode[6] & timingBus[6]));
        haltNow    = regRef & instr_q[0];
    end

    // Next-state logic: start launches a halted machine at T0, the counter
    // steps or clears while running (clear wins), IR is captured at the end
    // of T1 and I at the end of T2; HLT drops the run flag on its T3 edge.
    always_comb begin
        runState_d = runState_q;
        seqCount_d = seqCount_q;
        instr_d    = instr_q;
        indirect_d = indirect_q;
        case (runState_q)
            HALTED: begin
                seqCount_d = 3'd0;
                if (start) begin
                    runState_d = RUNNING;
                end
            end
            RUNNING: begin
                if (endOfInstr) begin
                    seqCount_d = 3'd0;
                end else begin
                    seqCount_d = seqCount_q + 3'd1;
                end
                if (haltNow) begin
                    runState_d = HALTED;
                end
                if (timingBus[1]) begin
                    instr_d = mem_data;
                end
                if (timingBus[2]) begin
                    indirect_d = instr_q[15];
                end
            end
            default: begin
                runState_d = HALTED;
                seqCount_d = 3'd0;
            end
        endcase
    end

    // State registers; an asynchronous reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runState_q <= HALTED;
            seqCount_q <= 3'd0;
            instr_q    <= 16'h0000;
            indirect_q <= 1'b0;
        end else begin
            runState_q <= runState_d;
            seqCount_q <= seqCount_d;
            instr_q    <= instr_d;
            indirect_q <= indirect_d;
        end
    end

    assign dec_out1 = timingBus;
    assign dec_out2 = opDecode;
    assign iff_data = indirect_q;
    assign r        = regRef;
    assign p        = ioRef;
    assign ir_data  = instr_q[11:0];
    assign ir_load  = timingBus[1];
    assign sc_clr   = endOfInstr;
    assign running  = isRunning;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed bench for control_sequencer. Each step drives
// start/mem_data and pushes the output vector expected after the next rising
// edge onto a scoreboard queue; the check pops it one time unit after the edge.
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] mem_data;
    logic [7:0]  dec_out1;
    logic [7:0]  dec_out2;
    logic        iff_data;
    logic        r;
    logic        p;
    logic [11:0] ir_data;
    logic        ir_load;
    logic        sc_clr;
    logic        running;

    typedef struct {
        string       tag;
        logic [33:0] expv;
    } expEntry_t;

    expEntry_t scoreboard[$];
    int compareCount = 0;
    int failCount    = 0;

    control_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mem_data (mem_data),
        .dec_out1 (dec_out1),
        .dec_out2 (dec_out2),
        .iff_data (iff_data),
        .r        (r),
        .p        (p),
        .ir_data  (ir_data),
        .ir_load  (ir_load),
        .sc_clr   (sc_clr),
        .running  (running)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs an expected output set: {dec_out1, dec_out2, iff, r, p, ir_data, ir_load, sc_clr, running}.
    function automatic logic [33:0] ev(input logic [7:0] t, input logic [7:0] d,
                                       input logic i, input logic rr, input logic pp,
                                       input logic [11:0] ir, input logic ld,
                                       input logic clr, input logic run);
        return {t, d, i, rr, pp, ir, ld, clr, run};
    endfunction

    // Drives the inputs for the coming edge and records what must follow it.
    task automatic applyStimulus(input logic st, input logic [15:0] md,
                                 input string tag, input logic [33:0] expv);
        expEntry_t e;
        start    = st;
        mem_data = md;
        e.tag    = tag;
        e.expv   = expv;
        scoreboard.push_back(e);
    endtask

    // Optionally waits for the edge, then pops and compares one expected entry.
    task automatic checkOutput(input bit waitEdge);
        expEntry_t   e;
        logic [33:0] obs;
        if (waitEdge) begin
            @(posedge clk);
            #1;
        end
        compareCount++;
        if (scoreboard.size() == 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e   = scoreboard.pop_front();
            obs = {dec_out1, dec_out2, iff_data, r, p, ir_data, ir_load, sc_clr, running};
            assert (obs === e.expv) else begin
                failCount++;
                $error("[TB] FAIL %s observed t=%h d=%h i=%b r=%b p=%b ir=%h ld=%b clr=%b run=%b expected t=%h d=%h i=%b r=%b p=%b ir=%h ld=%b clr=%b run=%b",
                       e.tag,
                       obs[33:26], obs[25:18], obs[17], obs[16], obs[15], obs[14:3], obs[2], obs[1], obs[0],
                       e.expv[33:26], e.expv[25:18], e.expv[17], e.expv[16], e.expv[15], e.expv[14:3],
                       e.expv[2], e.expv[1], e.expv[0]);
            end
        end
    endtask

    // Directed sequence covering reset, fetch, CLA, ADD, I/O, HLT/restart and mid-instruction reset.
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        mem_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, 16'h0000, "reset_state", ev(8'h00, 8'h01, 0, 0, 0, 12'h000, 0, 0, 0));
        checkOutput(1'b0);
        rst_n = 1'b1;

        // Reset then start
        applyStimulus(1'b1, 16'h0000, "start_T0",   ev(8'h01, 8'h01, 0, 0, 0, 12'h000, 0, 0, 1));
        checkOutput(1'b1);

        // Register-reference CLA
        applyStimulus(1'b0, 16'h7800, "cla_T1",     ev(8'h02, 8'h01, 0, 0, 0, 12'h000, 1, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h7800, "cla_T2",     ev(8'h04, 8'h80, 0, 0, 0, 12'h800, 0, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "cla_T3",     ev(8'h08, 8'h80, 0, 1, 0, 12'h800, 0, 1, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "cla_next_T0", ev(8'h01, 8'h80, 0, 0, 0, 12'h800, 0, 0, 1));
        checkOutput(1'b1);

        // Memory-reference ADD direct; a start pulse mid-instruction is ignored
        applyStimulus(1'b0, 16'h1123, "add_T1",     ev(8'h02, 8'h80, 0, 0, 0, 12'h800, 1, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h1123, "add_T2",     ev(8'h04, 8'h02, 0, 0, 0, 12'h123, 0, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "add_T3",     ev(8'h08, 8'h02, 0, 0, 0, 12'h123, 0, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b1, 16'h0000, "add_T4_start_ignored", ev(8'h10, 8'h02, 0, 0, 0, 12'h123, 0, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "add_T5",     ev(8'h20, 8'h02, 0, 0, 0, 12'h123, 0, 1, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "add_next_T0", ev(8'h01, 8'h02, 0, 0, 0, 12'h123, 0, 0, 1));
        checkOutput(1'b1);

        // I/O instruction
        applyStimulus(1'b0, 16'hF800, "io_T1",      ev(8'h02, 8'h02, 0, 0, 0, 12'h123, 1, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'hF800, "io_T2",      ev(8'h04, 8'h80, 0, 0, 0, 12'h800, 0, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "io_T3",      ev(8'h08, 8'h80, 1, 0, 1, 12'h800, 0, 1, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "io_next_T0", ev(8'h01, 8'h80, 1, 0, 0, 12'h800, 0, 0, 1));
        checkOutput(1'b1);

        // Halt, idle, then restart
        applyStimulus(1'b0, 16'h7001, "hlt_T1",     ev(8'h02, 8'h80, 1, 0, 0, 12'h800, 1, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h7001, "hlt_T2",     ev(8'h04, 8'h80, 1, 0, 0, 12'h001, 0, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "hlt_T3",     ev(8'h08, 8'h80, 0, 1, 0, 12'h001, 0, 1, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "halted_1",   ev(8'h00, 8'h80, 0, 0, 0, 12'h001, 0, 0, 0));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h5555, "halted_2",   ev(8'h00, 8'h80, 0, 0, 0, 12'h001, 0, 0, 0));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h5555, "halted_3",   ev(8'h00, 8'h80, 0, 0, 0, 12'h001, 0, 0, 0));
        checkOutput(1'b1);
        applyStimulus(1'b1, 16'h0000, "restart_T0", ev(8'h01, 8'h80, 0, 0, 0, 12'h001, 0, 0, 1));
        checkOutput(1'b1);

        // BSA interrupted by asynchronous reset during T4
        applyStimulus(1'b0, 16'h5010, "bsa_T1",     ev(8'h02, 8'h80, 0, 0, 0, 12'h001, 1, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h5010, "bsa_T2",     ev(8'h04, 8'h20, 0, 0, 0, 12'h010, 0, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "bsa_T3",     ev(8'h08, 8'h20, 0, 0, 0, 12'h010, 0, 0, 1));
        checkOutput(1'b1);
        applyStimulus(1'b0, 16'h0000, "bsa_T4",     ev(8'h10, 8'h20, 0, 0, 0, 12'h010, 0, 0, 1));
        checkOutput(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        applyStimulus(1'b0, 16'h0000, "async_reset_mid_T4", ev(8'h00, 8'h01, 0, 0, 0, 12'h000, 0, 0, 0));
        checkOutput(1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0000, "post_reset_idle", ev(8'h00, 8'h01, 0, 0, 0, 12'h000, 0, 0, 0));
        checkOutput(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Timing and decode front end of the basic-computer control path.
- Holds the run flag S, the 3-bit sequence counter SC, the 16-bit instruction register IR and the indirect flip-flop I.
- Drives the one-hot timing bus T0..T7, the opcode decode bus D0..D7, the register-reference strobe r, the I/O strobe p and IR[11:0].
- These outputs feed the per-register control units (AC, AR, PC, DR, ...).

Parameters:
None. Widths are fixed by the basic-computer ISA.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  run request pulse; sets S when halted
- mem_data  input  16  memory read word; captured into IR at T1
- dec_out1  output  8  one-hot timing: bit k = Tk, all zero when S=0
- dec_out2  output  8  opcode decode: bit k = (IR[14:12]==k)
- iff_data  output  1  I flip-flop (indirect/type bit)
- r  output  1  register-reference strobe = D7 & ~I & T3
- p  output  1  I/O strobe = D7 & I & T3
- ir_data  output  12  IR[11:0]
- ir_load  output  1  high during T1 while running (IR capture cycle)
- sc_clr  output  1  end-of-instruction strobe (SC clears next edge)
- running  output  1  S flag

Behaviour:
- Reset (asynchronous, rst_n=0): S=0, SC=0, IR=16'h0000, I=0.
  - Resulting outputs: dec_out1=8'h00, dec_out2=8'h01, iff_data=0, r=0, p=0, ir_data=12'h000, ir_load=0, sc_clr=0, running=0.
  - Reset asserted mid-instruction aborts the instruction immediately. No partial state survives.
- Start:
  - start=1 while S=0: S=1 on the next edge, SC stays 0, so T0 is active in the following cycle.
  - start while S=1 is ignored.
- Sequence counter:
  - While S=1, SC increments by 1 each edge unless sc_clr=1, in which case SC goes to 0.
  - If SC=7 with no clear, SC wraps to 0. This is a defensive case; legal opcodes never reach T7.
  - While S=0, SC holds 0.
- dec_out1 = (8'h01 << SC) gated by S. Purely combinational from registers.
- IR load: on the edge ending T1 (SC=1, S=1), IR <= mem_data. ir_load = S & T1.
- I load: on the edge ending T2, I <= IR[15]. dec_out2 decodes the IR register combinationally, so D is valid from T2 onward.
- sc_clr (combinational, gated by S) = r | p | (D0|D1|D2|D5)&T5 | (D3|D4)&T4 | D6&T6.
  - Every instruction therefore completes in 4, 5, 6 or 7 cycles including fetch.
  - The next instruction starts at T0 in the cycle after sc_clr.
- Halt: HLT = r & IR[0].
  - On that edge S <= 0 and SC <= 0. dec_out1 is all zero from the next cycle.
  - IR and I hold their values until the next fetch.
  - Only start resumes execution.
- Simultaneous events:
  - sc_clr and the SC increment in the same cycle: clear wins.
  - HLT and sc_clr always coincide. Both act, and the result is SC=0, S=0.
- No combinational path from start or mem_data to any output.

Test Plan:
1. Reset then start.
   - rst_n low 2 cycles, release, pulse start for 1 cycle.
   - Required: running=1 next cycle; dec_out1 sequence 8'h01, 8'h02, 8'h04, ...; ir_load=1 only in the 8'h02 cycle.
2. Register-reference CLA.
   - mem_data=16'h7800 at T1.
   - Required: at T2 dec_out2=8'h80, iff_data=0.
   - Required: at T3 r=1, p=0, ir_data=12'h800, sc_clr=1.
   - Required: the next cycle is T0 again.
3. Memory-reference ADD direct.
   - mem_data=16'h1123.
   - Required: dec_out2=8'h02 from T2; sc_clr=1 only at T5 (dec_out1=8'h20); the next cycle is T0.
4. I/O instruction.
   - mem_data=16'hF800.
   - Required: iff_data=1, p=1, r=0 at T3; sc_clr at T3.
5. Halt.
   - mem_data=16'h7001.
   - Required: at T3 r=1 and sc_clr=1; the next cycle running=0, dec_out1=8'h00.
   - Required: a start pulse 3 cycles later resumes at T0.
6. Asynchronous reset mid-instruction.
   - Assert rst_n=0 between edges during T4 of a BSA (16'h5010).
   - Required: outputs reach reset values immediately without waiting for a clock edge; running=0.
